// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - Scan-code byte input and key-event output bundle for ps2_key_decoder
interface ps2_key_decoder_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;

    modport master (
        input  rx_data,
        input  rx_valid,
        output key_down,
        output last_change,
        output key_valid
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  key_down,
        input  last_change,
        input  key_valid
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code byte stream to live key map with make/break events
// Optional feature macro: PS2_KEY_REPEAT_EN (report typematic repeat makes as events)
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    ps2_key_decoder_if.master kif
);
`ifdef PS2_KEY_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    state_t           state, state_nxt, eff_state;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [2:0]       skip_cnt, skip_nxt;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic [8:0]       idx;
    logic             set_en, clr_en, evt;
    logic             is_ignored, illegal_prefix;
    logic [511:0]     key_down_r;
    logic [8:0]       last_change_r;
    logic             key_valid_r;

    // Input byte is registered first, so events appear one edge after sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= kif.rx_data;
            rx_valid_q <= kif.rx_valid;
        end
    end

    always_comb begin
        case (rx_data_q)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:                                  is_ignored = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        skip_nxt       = skip_cnt;
        tmo_nxt        = tmo_cnt;
        set_en         = 1'b0;
        clr_en         = 1'b0;
        evt            = 1'b0;
        illegal_prefix = 1'b0;
        eff_state      = state;
        idx            = {1'b0, rx_data_q};
        if (rx_valid_q) begin
            tmo_nxt = '0;
            if (state == SKIP) begin
                skip_nxt = skip_cnt - 3'd1;
                if (skip_nxt == 3'd0)
                    state_nxt = IDLE;
            end else begin
                case (rx_data_q)
                    8'hE0, 8'hE1: illegal_prefix = (state != IDLE);
                    8'hF0:        illegal_prefix = (state == BRK) || (state == EXT_BRK);
                    default:      illegal_prefix = 1'b0;
                endcase
                // A misplaced prefix restarts decoding with that byte as the first one.
                if (illegal_prefix)
                    eff_state = IDLE;
                idx = {(eff_state == EXT) || (eff_state == EXT_BRK), rx_data_q};
                if (rx_data_q == 8'hE0) begin
                    state_nxt = EXT;
                end else if (rx_data_q == 8'hF0) begin
                    state_nxt = (eff_state == EXT) ? EXT_BRK : BRK;
                end else if (rx_data_q == 8'hE1) begin
                    state_nxt = SKIP;
                    skip_nxt  = 3'd7;
                end else begin
                    state_nxt = IDLE;
                    if (!is_ignored) begin
                        if ((eff_state == BRK) || (eff_state == EXT_BRK)) begin
                            clr_en = 1'b1;
                            evt    = 1'b1;
                        end else if (!key_down_r[idx]) begin
                            set_en = 1'b1;
                            evt    = 1'b1;
                        end else begin
                            evt = REPEAT_EN;
                        end
                    end
                end
            end
        end else if (state != IDLE) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_nxt = IDLE;
                tmo_nxt   = '0;
            end else begin
                tmo_nxt = tmo_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tmo_cnt  <= tmo_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_down_r    <= '0;
            last_change_r <= '0;
            key_valid_r   <= 1'b0;
        end else begin
            key_valid_r <= evt;
            if (evt)
                last_change_r <= idx;
            if (set_en)
                key_down_r[idx] <= 1'b1;
            if (clr_en)
                key_down_r[idx] <= 1'b0;
        end
    end

    assign kif.key_down    = key_down_r;
    assign kif.last_change = last_change_r;
    assign kif.key_valid   = key_valid_r;
endmodule
